// File: rtl/nv_ram_fifo_ctrl_60x84.sv
// FIFO controller driving a 60x84 two-port RAM.
// Hides the re/ore read pipeline behind valid/ready push and pop ports.
module nv_ram_fifo_ctrl_60x84 #(
  parameter int DEPTH = 60,
  parameter int WIDTH = 84,
  parameter int AW    = 6
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [6:0]       fifo_count,
  output logic             fifo_idle,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]    occ_q, occ_d;
  logic [6:0]    unread_q, unread_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;
  logic          push, pop;
  logic          unused_ok;

  assign unused_ok = ^pwrbus_ram_pd;

  always_comb begin
    wr_prdy = occ_q < 7'(DEPTH);
    push    = wr_pvld & wr_prdy & nvdla_core_rstn;
    ram_ore = s1_vld_q & (~s2_vld_q | rd_prdy) & nvdla_core_rstn;
    ram_re  = (unread_q != 7'd0) & (~s1_vld_q | ram_ore)
            & nvdla_core_rstn;
    // data lives in the RAM output register; s2 gates stale dout
    rd_pvld = s2_vld_q & nvdla_core_rstn;
    pop     = rd_pvld & rd_prdy;
  end

  always_comb begin
    ram_we      = push;
    ram_wa      = wr_ptr_q;
    ram_di      = wr_pd;
    ram_ra      = rd_ptr_q;
    rd_pd       = ram_dout;
    fifo_count  = occ_q;
    fifo_idle   = occ_q == 7'd0;
    ram_byp_sel = 1'b0;
    ram_dbyp    = '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
    if (ram_re)
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    if (ram_re)
      s1_vld_d = 1'b1;
    else if (ram_ore)
      s1_vld_d = 1'b0;
    if (ram_ore)
      s2_vld_d = 1'b1;
    else if (pop)
      s2_vld_d = 1'b0;
    unread_d = unread_q + 7'(push) - 7'(ram_re);
    occ_d    = occ_q + 7'(push) - 7'(pop);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      unread_q <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      unread_q <= unread_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

endmodule
